tile_color_sequencer: RTL and testbench

TILE_COLOR_SEQUENCER -- requirements
Module: tile_color_sequencer

---
 rtl/tile_seq_pkg.sv | 43 ++++
 rtl/tile_color_sequencer_if.sv | 26 ++
 rtl/tile_counter.sv | 64 ++++++
 rtl/tile_color_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tile_color_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_seq_pkg.sv
// -----------------------------------------------------------------------------
// tile_seq_pkg
// Shared definitions for the tile colour sequencer:
//   mode_e       - counter stepping mode (WRAP / BOUNCE)
//   run_state_e  - run/idle control state
//   IDX_W        - width of a tile index (up to 64 tiles)
//   COLOR_W      - width of one VGA colour channel
//   rep_color()  - replicates a CH_W-bit channel value MSB-first to COLOR_W bits
// -----------------------------------------------------------------------------
package tile_seq_pkg;

  typedef enum logic {
    WRAP   = 1'b0,
    BOUNCE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  localparam int IDX_W   = 6;
  localparam int COLOR_W = 10;

  // val carries ch_w significant bits, zero-extended. The pattern is stacked
  // until it covers COLOR_W bits, then the excess LSBs are dropped so the
  // result always starts with the channel MSB.
  function automatic logic [COLOR_W-1:0] rep_color(input logic [3:0] val, input int ch_w);
    logic [19:0] acc;
    int          bits;
    acc  = '0;
    bits = 0;
    for (int i = 0; i < COLOR_W; i++) begin
      if (bits < COLOR_W) begin
        acc  = (acc << ch_w) | {16'b0, val};
        bits = bits + ch_w;
      end
    end
    acc = acc >> (bits - COLOR_W);
    return acc[COLOR_W-1:0];
  endfunction

endpackage

// File: rtl/tile_color_sequencer_if.sv
// -----------------------------------------------------------------------------
// tile_color_sequencer_if
// VGA-side signals of the tile colour sequencer.
//   VGA_vsync                  - V_SYNC from the timing generator, active low
//   pixel_X_pos / pixel_Y_pos  - coordinates of the pixel being drawn
//   VGA_red/green/blue         - colour for that pixel
// master: timing generator / DAC side; slave: the sequencer.
// -----------------------------------------------------------------------------
interface tile_color_sequencer_if import tile_seq_pkg::*;;
  logic               VGA_vsync;
  logic [9:0]         pixel_X_pos;
  logic [9:0]         pixel_Y_pos;
  logic [COLOR_W-1:0] VGA_red;
  logic [COLOR_W-1:0] VGA_green;
  logic [COLOR_W-1:0] VGA_blue;

  modport master (
    output VGA_vsync, pixel_X_pos, pixel_Y_pos,
    input  VGA_red, VGA_green, VGA_blue
  );

  modport slave (
    input  VGA_vsync, pixel_X_pos, pixel_Y_pos,
    output VGA_red, VGA_green, VGA_blue
  );
endinterface

// File: rtl/tile_counter.sv
// -----------------------------------------------------------------------------
// tile_counter
// CW-bit up/down counter for one tile.
//   Clock, Reset - clock, asynchronous active-high reset
//   step         - advance by one this cycle (already gated by freeze)
//   up           - requested direction, 1 = up
//   mode         - WRAP: modulo 2^CW; BOUNCE: reverse at the extremes
//   rev_clr      - clear the ping-pong reversal flag
//   count        - current counter value
// -----------------------------------------------------------------------------
module tile_counter import tile_seq_pkg::*; #(
  parameter int CW = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          step,
  input  logic          up,
  input  mode_e         mode,
  input  logic          rev_clr,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX = '1;

  logic rev;
  logic eff_up;

  assign eff_up = up ^ ((mode == BOUNCE) & rev);

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      rev   <= 1'b0;
    end else begin
      if (step) begin
        if (mode == WRAP) begin
          count <= eff_up ? count + 1'b1 : count - 1'b1;
        end else if (eff_up) begin
          // Already at the top (e.g. bounce just enabled): turn around now.
          if (count == MAX) begin
            count <= count - 1'b1;
            rev   <= ~rev;
          end else begin
            count <= count + 1'b1;
            if (count == MAX - 1'b1) rev <= ~rev;
          end
        end else begin
          if (count == '0) begin
            count <= count + 1'b1;
            rev   <= ~rev;
          end else begin
            count <= count - 1'b1;
            if (count == CW'(1)) rev <= ~rev;
          end
        end
      end
      // A mode change overrides any toggle from a coincident step.
      if (rev_clr) rev <= 1'b0;
    end
  end

endmodule

// File: rtl/tile_color_sequencer.sv
// -----------------------------------------------------------------------------
// tile_color_sequencer
// Splits the active area into TILES_X x TILES_Y tiles, each with a counter
// that steps once every FRAME_DIV frames; the counter value is shown as the
// tile colour.
//   Clock, Reset        - 25 MHz pixel clock, asynchronous active-high reset
//   vga                 - vsync / pixel coordinates in, colour out
//   start               - pulse: start running, clear all freezes
//   freeze_req/idx      - pulse: freeze tile idx (row-major), idx >= NT ignored
//   dir                 - per-tile direction, 1 = up
//   chan_en             - per-tile {R,G,B} enables, tile i at [3i+2:3i]
//   bounce              - 0 = wrap mode, 1 = ping-pong mode
//   step_tick           - one-cycle pulse on each counter step
// -----------------------------------------------------------------------------
module tile_color_sequencer import tile_seq_pkg::*; #(
  parameter int TILES_X   = 2,
  parameter int TILES_Y   = 2,
  parameter int CH_W      = 1,
  parameter int FRAME_DIV = 50,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                           Clock,
  input  logic                           Reset,
  tile_color_sequencer_if.slave          vga,
  input  logic                           start,
  input  logic                           freeze_req,
  input  logic [IDX_W-1:0]               freeze_idx,
  input  logic [TILES_X*TILES_Y-1:0]     dir,
  input  logic [3*TILES_X*TILES_Y-1:0]   chan_en,
  input  logic                           bounce,
  output logic                           step_tick
);

  localparam int NT     = TILES_X * TILES_Y;
  localparam int CW     = 3 * CH_W;
  localparam int TILE_W = H_RES / TILES_X;
  localparam int TILE_H = V_RES / TILES_Y;

  run_state_e       state, state_nxt;
  logic             running;
  logic             vsync_q;
  logic             frame_evt;
  logic [6:0]       frame_cnt;
  logic [NT-1:0]    freeze;
  logic [NT-1:0]    freeze_hit;
  logic             bounce_q;
  logic             rev_clr;
  mode_e            mode;
  logic [CW-1:0]    tile_cnt [NT];

  // ---------------- run control ----------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = ST_RUN;
  end

  assign running = (state == ST_RUN);

  // ---------------- frame divider ----------------
  assign frame_evt = vsync_q & ~vga.VGA_vsync;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vsync_q   <= 1'b0;
      frame_cnt <= '0;
      step_tick <= 1'b0;
    end else begin
      vsync_q   <= vga.VGA_vsync;
      step_tick <= 1'b0;
      if (running && frame_evt) begin
        if (frame_cnt == 7'(FRAME_DIV - 1)) begin
          frame_cnt <= '0;
          step_tick <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- freeze and mode tracking ----------------
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    freeze_hit = '0;
    for (int i = 0; i < NT; i++) begin
      if (freeze_req && (freeze_idx == IDX_W'(i))) freeze_hit[i] = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      freeze   <= '0;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= bounce;
      if (start) freeze <= '0;
      else       freeze <= freeze | freeze_hit;
    end
  end

  assign rev_clr = bounce ^ bounce_q;
  assign mode    = mode_e'(bounce);

  // A freeze request arriving together with a step already blocks that step.
  for (genvar g = 0; g < NT; g++) begin : g_tile
    tile_counter #(.CW(CW)) u_tile_counter (
      .Clock   (Clock),
      .Reset   (Reset),
      .step    (step_tick & ~freeze[g] & ~freeze_hit[g]),
      .up      (dir[g]),
      .mode    (mode),
      .rev_clr (rev_clr),
      .count   (tile_cnt[g])
    );
  end

  // ---------------- pixel colour ----------------
  logic [2:0]       tx, ty;
  logic [IDX_W-1:0] sel;
  logic [CW-1:0]    cur;
  logic [2:0]       en;
  logic             in_area;

  always_comb begin
    tx  = '0;
    ty  = '0;
    cur = '0;
    en  = '0;
    // Comparator chains: the last boundary passed gives the tile column/row.
    for (int k = 1; k < TILES_X; k++) begin
      if (vga.pixel_X_pos >= 10'(k * TILE_W)) tx = 3'(k);
    end
    for (int k = 1; k < TILES_Y; k++) begin
      if (vga.pixel_Y_pos >= 10'(k * TILE_H)) ty = 3'(k);
    end
    sel = IDX_W'(int'(ty) * TILES_X + int'(tx));
    for (int i = 0; i < NT; i++) begin
      if (sel == IDX_W'(i)) begin
        cur = tile_cnt[i];
        en  = chan_en[3*i +: 3];
      end
    end
    in_area = (vga.pixel_X_pos < 10'(H_RES)) && (vga.pixel_Y_pos < 10'(V_RES));

    vga.VGA_red   = '0;
    vga.VGA_green = '0;
    vga.VGA_blue  = '0;
    if (in_area) begin
      if (en[2]) vga.VGA_red   = rep_color(4'(cur[CW-1 -: CH_W]), CH_W);
      if (en[1]) vga.VGA_green = rep_color(4'(cur[2*CH_W-1 -: CH_W]), CH_W);
      if (en[0]) vga.VGA_blue  = rep_color(4'(cur[CH_W-1:0]), CH_W);
    end
  end

endmodule

// File: tb/tb_tile_color_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tile_color_sequencer
// Scoreboard bench. Stimulus places a pixel on the bus and queues the colour
// it expects there; a monitor on the falling clock edge pops and compares.
// DUT a: default parameters. DUT b: 4x3 tiles, CH_W = 2, FRAME_DIV = 2.
// -----------------------------------------------------------------------------
module tb_tile_color_sequencer;
  import tile_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a
  logic        rst_a = 1'b1;
  logic        start_a = 1'b0;
  logic        freeze_req_a = 1'b0;
  logic [5:0]  freeze_idx_a = '0;
  logic [3:0]  dir_a = '0;
  logic [11:0] chan_en_a = '1;
  logic        bounce_a = 1'b0;
  logic        step_tick_a;
  tile_color_sequencer_if vga_a ();

  tile_color_sequencer u_dut_a (
    .Clock      (clk),
    .Reset      (rst_a),
    .vga        (vga_a),
    .start      (start_a),
    .freeze_req (freeze_req_a),
    .freeze_idx (freeze_idx_a),
    .dir        (dir_a),
    .chan_en    (chan_en_a),
    .bounce     (bounce_a),
    .step_tick  (step_tick_a)
  );

  // DUT b
  logic        rst_b = 1'b1;
  logic        start_b = 1'b0;
  logic        freeze_req_b = 1'b0;
  logic [5:0]  freeze_idx_b = '0;
  logic [11:0] dir_b = 12'b0010_0000_0000;
  logic [35:0] chan_en_b = '1;
  logic        bounce_b = 1'b0;
  logic        step_tick_b;
  tile_color_sequencer_if vga_b ();

  tile_color_sequencer #(
    .TILES_X(4), .TILES_Y(3), .CH_W(2), .FRAME_DIV(2), .H_RES(640), .V_RES(480)
  ) u_dut_b (
    .Clock      (clk),
    .Reset      (rst_b),
    .vga        (vga_b),
    .start      (start_b),
    .freeze_req (freeze_req_b),
    .freeze_idx (freeze_idx_b),
    .dir        (dir_b),
    .chan_en    (chan_en_b),
    .bounce     (bounce_b),
    .step_tick  (step_tick_b)
  );

  int checks = 0;
  int errors = 0;
  int ticks_a = 0;
  int ticks_b = 0;
  int exp_ticks_a = 0;

  // scoreboard
  logic        probe = 1'b0;
  bit          dut_q  [$];
  string       name_q [$];
  logic [29:0] rgb_q  [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (step_tick_a === 1'b1) ticks_a++;
    if (step_tick_b === 1'b1) ticks_b++;
  end

  always @(negedge clk) begin
    if (probe) begin
      if (rgb_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        bit          d;
        string       nm;
        logic [29:0] exp;
        logic [29:0] act;
        d   = dut_q.pop_front();
        nm  = name_q.pop_front();
        exp = rgb_q.pop_front();
        act = d ? {vga_b.VGA_red, vga_b.VGA_green, vga_b.VGA_blue}
                : {vga_a.VGA_red, vga_a.VGA_green, vga_a.VGA_blue};
        check(nm, {2'b0, act}, {2'b0, exp});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // CH_W = 1 with all channels enabled: each counter bit fills one channel.
  function automatic logic [29:0] exp_ch1(input logic [2:0] v);
    return {{10{v[2]}}, {10{v[1]}}, {10{v[0]}}};
  endfunction

  task automatic probe_px(input bit d, input string nm, input int x, input int y,
                          input logic [29:0] exp);
    if (d) begin
      vga_b.pixel_X_pos = 10'(x);
      vga_b.pixel_Y_pos = 10'(y);
    end else begin
      vga_a.pixel_X_pos = 10'(x);
      vga_a.pixel_Y_pos = 10'(y);
    end
    dut_q.push_back(d);
    name_q.push_back(nm);
    rgb_q.push_back(exp);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic probe_tile_a(input string nm, input int tile, input logic [2:0] v);
    probe_px(1'b0, nm, (tile % 2) * 320 + 10, (tile / 2) * 240 + 10, exp_ch1(v));
  endtask

  // Each frame: one vsync low cycle, then two high cycles. With frz set,
  // freeze_req is raised in the cycle step_tick is high after the last frame.
  task automatic frames(input bit d, input int n, input bit frz, input logic [5:0] idx);
    for (int f = 0; f < n; f++) begin
      if (d) vga_b.VGA_vsync = 1'b0; else vga_a.VGA_vsync = 1'b0;
      @(posedge clk); #1;
      if (d) vga_b.VGA_vsync = 1'b1; else vga_a.VGA_vsync = 1'b1;
      if (frz && f == n - 1) begin
        freeze_req_a = 1'b1;
        freeze_idx_a = idx;
      end
      @(posedge clk); #1;
      freeze_req_a = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic step_a();
    frames(1'b0, 50, 1'b0, 6'd0);
    exp_ticks_a++;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  initial begin
    int seq [10];
    seq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4};
    vga_a.VGA_vsync = 1'b1;
    vga_a.pixel_X_pos = '0;
    vga_a.pixel_Y_pos = '0;
    vga_b.VGA_vsync = 1'b1;
    vga_b.pixel_X_pos = '0;
    vga_b.pixel_Y_pos = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset state, then idle until start
    for (int t = 0; t < 4; t++) probe_tile_a($sformatf("reset_tile%0d", t), t, 3'd0);
    rst_a = 1'b0;
    frames(1'b0, 50, 1'b0, 6'd0);
    check("idle_no_tick", ticks_a, exp_ticks_a);
    probe_tile_a("idle_tile0", 0, 3'd0);

    // first step, all up
    dir_a = 4'b1111;
    pulse_start_a();
    frames(1'b0, 49, 1'b0, 6'd0);
    check("no_tick_49_frames", ticks_a, exp_ticks_a);
    frames(1'b0, 1, 1'b0, 6'd0);
    exp_ticks_a++;
    check("tick_at_50_frames", ticks_a, exp_ticks_a);
    probe_px(1'b0, "first_px00", 0, 0, {10'h000, 10'h000, 10'h3FF});
    for (int t = 1; t < 4; t++) probe_tile_a($sformatf("first_tile%0d", t), t, 3'd1);

    // wrap mode, tile 0 counting down from 0
    reset_a();
    dir_a = 4'b1110;
    pulse_start_a();
    step_a();
    probe_px(1'b0, "wrap_down_px1010", 10, 10, {10'h3FF, 10'h3FF, 10'h3FF});
    probe_tile_a("wrap_tile1", 1, 3'd1);
    probe_px(1'b0, "offscreen_y480", 10, 480, 30'd0);
    probe_px(1'b0, "offscreen_x640", 640, 10, 30'd0);
    dir_a = 4'b1111;
    step_a();
    probe_tile_a("wrap_up_tile0", 0, 3'd0);
    probe_tile_a("wrap_tile1_2", 1, 3'd2);

    // ping-pong
    reset_a();
    bounce_a = 1'b1;
    dir_a = 4'b1111;
    pulse_start_a();
    for (int s = 0; s < 10; s++) begin
      step_a();
      probe_tile_a($sformatf("bounce_step%0d", s + 1), 0, 3'(seq[s]));
    end
    // toggling the mode clears the reversal: next step goes up again
    bounce_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bounce_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step_a();
    probe_tile_a("bounce_rev_clear", 0, 3'd5);

    // freeze
    reset_a();
    bounce_a = 1'b0;
    dir_a = 4'b1111;
    pulse_start_a();
    frames(1'b0, 50, 1'b1, 6'd3);
    exp_ticks_a++;
    probe_tile_a("freeze_on_tick_t3", 3, 3'd0);
    probe_tile_a("freeze_on_tick_t2", 2, 3'd1);
    step_a();
    probe_tile_a("frozen_t3", 3, 3'd0);
    freeze_req_a = 1'b1;
    freeze_idx_a = 6'd9;
    @(posedge clk); #1;
    freeze_req_a = 1'b0;
    step_a();
    probe_tile_a("idx9_ignored_t3", 3, 3'd0);
    probe_tile_a("idx9_ignored_t0", 0, 3'd3);
    probe_tile_a("idx9_ignored_t1", 1, 3'd3);
    pulse_start_a();
    step_a();
    probe_tile_a("unfrozen_t3", 3, 3'd1);
    probe_tile_a("unfrozen_t2", 2, 3'd4);
    // start and freeze_req together: start wins
    start_a = 1'b1;
    freeze_req_a = 1'b1;
    freeze_idx_a = 6'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    freeze_req_a = 1'b0;
    step_a();
    probe_tile_a("start_wins_t0", 0, 3'd5);
    check("ticks_after_freeze", ticks_a, exp_ticks_a);

    // reset mid-frame with counters non-zero
    frames(1'b0, 20, 1'b0, 6'd0);
    #2;
    rst_a = 1'b1;
    for (int t = 0; t < 4; t++) probe_tile_a($sformatf("midreset_tile%0d", t), t, 3'd0);
    rst_a = 1'b0;
    frames(1'b0, 50, 1'b0, 6'd0);
    check("post_reset_idle", ticks_a, exp_ticks_a);
    probe_tile_a("post_reset_tile0", 0, 3'd0);
    pulse_start_a();
    frames(1'b0, 49, 1'b0, 6'd0);
    check("post_reset_divider_cleared", ticks_a, exp_ticks_a);
    frames(1'b0, 1, 1'b0, 6'd0);
    exp_ticks_a++;
    check("post_reset_tick", ticks_a, exp_ticks_a);
    probe_tile_a("post_reset_tile2", 2, 3'd1);

    // DUT b: 4x3 tiles, 2-bit channels; tile 9 counts up, the rest down.
    // 39 steps: tile 9 = 6'b10_01_11, other tiles = 64-39 = 6'b01_10_01.
    rst_b = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    frames(1'b1, 78, 1'b0, 6'd0);
    check("b_ticks", ticks_b, 39);
    probe_px(1'b1, "b_px479_300_tile6", 479, 300, {10'h155, 10'h2AA, 10'h155});
    probe_px(1'b1, "b_px300_479_tile9", 300, 479, {10'h2AA, 10'h155, 10'h3FF});
    probe_px(1'b1, "b_px639_479_tile11", 639, 479, {10'h155, 10'h2AA, 10'h155});
    probe_px(1'b1, "b_offscreen", 640, 100, 30'd0);
    chan_en_b[28] = 1'b0;
    probe_px(1'b1, "b_tile9_green_off", 300, 479, {10'h2AA, 10'h000, 10'h3FF});

    repeat (2) @(posedge clk);
    check("scoreboard_drained", rgb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
